// File: rtl/number_guess_pkg.sv
// Shared types for the number-guess datapath: result codes, evaluator states, BCD limits.
package number_guess_pkg;
  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_LOW     = 2'b01,
    RES_HIGH    = 2'b10,
    RES_CORRECT = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    GEN   = 2'd0,
    IDLE  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } eval_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_ok(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/guess_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting right; free-runs unless restart.
module guess_lfsr16 (
  input  logic        clk,
  input  logic        restart,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic fb;
  assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

  always_ff @(posedge clk) begin
    if (restart) q <= seed;
    else         q <= {fb, q[15:1]};
  end
endmodule

// File: rtl/guess_evaluator.sv
// Scores BCD guesses against a random or player-loaded secret and tracks attempts.
module guess_evaluator
  import number_guess_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       restart,
  input  logic [1:0] max_digits,
  input  logic [3:0] guess_digit_1,
  input  logic [3:0] guess_digit_2,
  input  logic [3:0] guess_digit_3,
  input  logic       submit,
  input  logic       secret_load,
  output logic [1:0] result,
  output logic [3:0] attempts,
  output logic       game_over,
  output logic       win,
  output logic [3:0] secret_digit_1,
  output logic [3:0] secret_digit_2,
  output logic [3:0] secret_digit_3
);
  localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);

  eval_state_t     state_q, state_d;
  result_t         res_q, res_d;
  logic [3:0]      att_q, att_d;
  logic            win_q, win_d;
  logic [1:0]      md_q;
  logic [2:0][3:0] sec_q, sec_d, cap_q, cap_d;
  logic [2:0]      ok_q, ok_d;
  logic            sub_q, ld_q;
  logic [15:0]     lfsr;
  logic [2:0][3:0] gd;
  logic [2:0]      act;
  logic            sub_rise, ld_rise, gd_ok, cap_ok;

  guess_lfsr16 u_lfsr (.clk(clk), .restart(restart), .seed(LFSR_SEED), .q(lfsr));

  assign gd       = {guess_digit_3, guess_digit_2, guess_digit_1};
  assign act      = (md_q == 2'd3) ? 3'b111 : (md_q == 2'd2) ? 3'b011 : 3'b001;
  assign sub_rise = submit & ~sub_q;
  assign ld_rise  = secret_load & ~ld_q;
  assign gd_ok    = &(~act | {bcd_ok(gd[2]), bcd_ok(gd[1]), bcd_ok(gd[0])});
  // Inactive captured digits are already zero, so all three can be checked.
  assign cap_ok   = bcd_ok(cap_q[2]) & bcd_ok(cap_q[1]) & bcd_ok(cap_q[0]);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    att_d   = att_q;
    win_d   = win_q;
    sec_d   = sec_q;
    cap_d   = cap_q;
    ok_d    = ok_q;
    unique case (state_q)
      GEN: begin
        for (int k = 0; k < 3; k++) begin
          if (!act[k]) begin
            sec_d[k] = '0;
            ok_d[k]  = 1'b1;
          end else if (!ok_q[k] && bcd_ok(lfsr[4*k +: 4])) begin
            sec_d[k] = lfsr[4*k +: 4];
            ok_d[k]  = 1'b1;
          end
        end
        if (&ok_d) state_d = IDLE;
      end
      IDLE: begin
        if (sub_rise) begin
          for (int k = 0; k < 3; k++) cap_d[k] = act[k] ? gd[k] : 4'd0;
          state_d = CHECK;
        end else if (ld_rise && att_q == 4'd0 && gd_ok) begin
          for (int k = 0; k < 3; k++) sec_d[k] = act[k] ? gd[k] : 4'd0;
        end
      end
      CHECK: begin
        if (!cap_ok) begin
          res_d   = RES_NONE;
          state_d = IDLE;
        end else begin
          // Valid BCD nibbles concatenated MSD-first compare like the decimal values.
          if (cap_q < sec_q)      res_d = RES_LOW;
          else if (cap_q > sec_q) res_d = RES_HIGH;
          else                    res_d = RES_CORRECT;
          att_d = att_q + 4'd1;
          if (res_d == RES_CORRECT) begin
            win_d   = 1'b1;
            state_d = DONE;
          end else if (att_d == MAX_A) begin
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q <= GEN;
      res_q   <= RES_NONE;
      att_q   <= '0;
      win_q   <= 1'b0;
      sec_q   <= '0;
      cap_q   <= '0;
      ok_q    <= '0;
      sub_q   <= 1'b0;
      ld_q    <= 1'b0;
      md_q    <= (max_digits == 2'd0) ? 2'd1 : max_digits;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      att_q   <= att_d;
      win_q   <= win_d;
      sec_q   <= sec_d;
      cap_q   <= cap_d;
      ok_q    <= ok_d;
      sub_q   <= submit;
      ld_q    <= secret_load;
    end
  end

  assign result         = res_q;
  assign attempts       = att_q;
  assign win            = win_q;
  assign game_over      = (state_q == DONE);
  assign secret_digit_1 = game_over ? sec_q[0] : 4'd0;
  assign secret_digit_2 = game_over ? sec_q[1] : 4'd0;
  assign secret_digit_3 = game_over ? sec_q[2] : 4'd0;
endmodule

// File: tb/tb_guess_evaluator.sv
// Random and directed bench for guess_evaluator against a decimal-level game model.
module tb_guess_evaluator;
  localparam int MAXA = 8;
  localparam int MG = 0, MI = 1, MC = 2, MDN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       restart = 1'b1;
  logic [1:0] max_digits = 2'd3;
  logic [3:0] gd1 = 0, gd2 = 0, gd3 = 0;
  logic       submit = 1'b0, secret_load = 1'b0;
  logic [1:0] result;
  logic [3:0] attempts, sd1, sd2, sd3;
  logic       game_over, win;

  guess_evaluator #(.MAX_ATTEMPTS(MAXA), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .restart(restart), .max_digits(max_digits),
    .guess_digit_1(gd1), .guess_digit_2(gd2), .guess_digit_3(gd3),
    .submit(submit), .secret_load(secret_load),
    .result(result), .attempts(attempts), .game_over(game_over), .win(win),
    .secret_digit_1(sd1), .secret_digit_2(sd2), .secret_digit_3(sd3)
  );

  int vecs = 0, errs = 0;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: secret and guesses as decimal integers, LFSR as plain shift arithmetic.
  bit        m_on = 0;
  int        m_phase, m_res, m_att, m_win, m_md;
  int        m_sec[3], m_cap[3], m_got[3];
  bit [15:0] m_lfsr;
  bit        m_sp, m_lp;

  always @(posedge clk) begin
    int g[3];
    bit rs, rl, allok;
    g[0] = int'(gd1); g[1] = int'(gd2); g[2] = int'(gd3);
    if (restart) begin
      m_on = 1; m_phase = MG; m_res = 0; m_att = 0; m_win = 0;
      m_lfsr = 16'hACE1; m_sp = 0; m_lp = 0;
      m_md = (max_digits == 0) ? 1 : int'(max_digits);
      for (int k = 0; k < 3; k++) begin m_sec[k] = 0; m_cap[k] = 0; m_got[k] = 0; end
    end else if (m_on) begin
      rs = submit && !m_sp;
      rl = secret_load && !m_lp;
      case (m_phase)
        MG: begin
          allok = 1;
          for (int k = 0; k < 3; k++) begin
            if (k >= m_md) begin m_sec[k] = 0; m_got[k] = 1; end
            else if (!m_got[k] && ((m_lfsr >> (4 * k)) & 16'hF) <= 9) begin
              m_sec[k] = int'((m_lfsr >> (4 * k)) & 16'hF); m_got[k] = 1;
            end
            if (!m_got[k]) allok = 0;
          end
          if (allok) m_phase = MI;
        end
        MI: begin
          if (rs) begin
            for (int k = 0; k < 3; k++) m_cap[k] = (k < m_md) ? g[k] : 0;
            m_phase = MC;
          end else if (rl && m_att == 0) begin
            allok = 1;
            for (int k = 0; k < m_md; k++) if (g[k] > 9) allok = 0;
            if (allok) for (int k = 0; k < 3; k++) m_sec[k] = (k < m_md) ? g[k] : 0;
          end
        end
        MC: begin
          if (m_cap[0] > 9 || m_cap[1] > 9 || m_cap[2] > 9) begin
            m_res = 0; m_phase = MI;
          end else begin
            int gv, sv;
            gv = m_cap[2] * 100 + m_cap[1] * 10 + m_cap[0];
            sv = m_sec[2] * 100 + m_sec[1] * 10 + m_sec[0];
            m_res = (gv < sv) ? 1 : (gv > sv) ? 2 : 3;
            m_att++;
            if (m_res == 3) begin m_win = 1; m_phase = MDN; end
            else if (m_att == MAXA) m_phase = MDN;
            else m_phase = MI;
          end
        end
        default: ;
      endcase
      m_lfsr = (m_lfsr >> 1) | (16'(m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]) << 15);
      m_sp = submit; m_lp = secret_load;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      bit d;
      d = (m_phase == MDN);
      chk("result", 16'(result), 16'(m_res));
      chk("attempts", 16'(attempts), 16'(m_att));
      chk("game_over", 16'(game_over), 16'(d));
      chk("win", 16'(win), 16'(m_win));
      chk("secret_1", 16'(sd1), d ? 16'(m_sec[0]) : 16'd0);
      chk("secret_2", 16'(sd2), d ? 16'(m_sec[1]) : 16'd0);
      chk("secret_3", 16'(sd3), d ? 16'(m_sec[2]) : 16'd0);
    end
  end

  task automatic do_restart(input logic [1:0] md);
    @(negedge clk);
    restart = 1; max_digits = md; submit = 0; secret_load = 0;
    repeat (3) @(negedge clk);
    restart = 0;
    chk("rst_result", 16'(result), 16'd0);
    chk("rst_attempts", 16'(attempts), 16'd0);
    chk("rst_game_over", 16'(game_over), 16'd0);
    chk("rst_secret", {4'd0, sd3, sd2, sd1}, 16'd0);
    repeat (64) @(negedge clk);
  endtask

  task automatic set_d(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1);
    gd3 = a3; gd2 = a2; gd1 = a1;
  endtask

  task automatic press(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1);
    @(negedge clk); set_d(a3, a2, a1); submit = 1;
    @(negedge clk); submit = 0;
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1);
    @(negedge clk); set_d(a3, a2, a1); secret_load = 1;
    @(negedge clk); secret_load = 0;
  endtask

  initial begin
    // Random-secret game: reveal must be valid BCD and match the model's LFSR draw.
    do_restart(2'd3);
    for (int i = 0; i < MAXA && !game_over; i++)
      press(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
    chk("rand_game_over", 16'(game_over), 16'd1);
    chk("rand_sec_bcd", 16'(sd1 <= 9 && sd2 <= 9 && sd3 <= 9), 16'd1);

    // Two-player game with secret 456.
    do_restart(2'd3);
    load(4, 5, 6);
    press(1, 2, 3);
    chk("p123_result", 16'(result), 16'd1);
    chk("p123_attempts", 16'(attempts), 16'd1);
    press(7, 8, 9);
    chk("p789_result", 16'(result), 16'd2);
    chk("p789_attempts", 16'(attempts), 16'd2);
    press(4, 5, 6);
    chk("p456_result", 16'(result), 16'd3);
    chk("p456_win", 16'(win), 16'd1);
    chk("p456_game_over", 16'(game_over), 16'd1);
    chk("p456_secret", {4'd0, sd3, sd2, sd1}, 16'h0456);

    // One active digit; upper digits ignored; exhaust attempts.
    do_restart(2'd1);
    load(0, 0, 7);
    press(9, 9, 2);
    chk("md1_result", 16'(result), 16'd1);
    repeat (MAXA - 1) press(0, 0, 3);
    chk("exh_game_over", 16'(game_over), 16'd1);
    chk("exh_win", 16'(win), 16'd0);
    chk("exh_attempts", 16'(attempts), 16'(MAXA));
    press(0, 0, 7);
    chk("done_attempts", 16'(attempts), 16'(MAXA));

    // Held submit, late load ignored, invalid digit.
    do_restart(2'd3);
    load(5, 0, 0);
    @(negedge clk); set_d(1, 2, 3); submit = 1;
    repeat (20) @(negedge clk);
    submit = 0;
    @(negedge clk);
    chk("held_attempts", 16'(attempts), 16'd1);
    load(9, 9, 9);
    press(0, 0, 12);
    chk("bad_result", 16'(result), 16'd0);
    chk("bad_attempts", 16'(attempts), 16'd1);
    press(5, 0, 0);
    chk("kept_secret_win", 16'(win), 16'd1);

    // Restart landing on the CHECK cycle.
    do_restart(2'd3);
    load(1, 1, 1);
    press(0, 0, 0);
    @(negedge clk); set_d(2, 2, 2); submit = 1;
    @(negedge clk); submit = 0; restart = 1;
    @(negedge clk); restart = 0;
    chk("chk_rst_result", 16'(result), 16'd0);
    chk("chk_rst_attempts", 16'(attempts), 16'd0);

    // Random traffic under the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      restart     = ($urandom_range(0, 299) == 0);
      max_digits  = 2'($urandom_range(0, 3));
      submit      = ($urandom_range(0, 4) == 0);
      secret_load = ($urandom_range(0, 7) == 0);
      gd1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      gd2 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      gd3 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/guess_evaluator.md
Name: guess_evaluator

Overview:
- Consumer side of the digit-entry path: takes the three BCD guess digits produced by input_control, plus max_digits.
- On a submit press, compares the guess against a secret number and reports too low, too high or correct.
- Counts attempts and ends the game on a win or when attempts run out.
- Generates the secret with an internal LFSR, or loads it from the digit inputs (two-player mode). Drives the result/status LEDs and the secret reveal on the display.

Parameters:
- MAX_ATTEMPTS, 8: guesses allowed per game; legal range 1..15.
- LFSR_SEED, 16'hACE1: LFSR value loaded while restart is high; must be nonzero.

Ports:
- clk  in  1  system clock
- restart  in  1  synchronous, active-high reset
- max_digits  in  2  active digit count; 0 is treated as 1
- guess_digit_1  in  4  BCD, least significant
- guess_digit_2  in  4  BCD
- guess_digit_3  in  4  BCD, most significant
- submit  in  1  debounced level from the submit pushbutton
- secret_load  in  1  debounced level; captures the guess digits as the secret
- result  out  2  00 none, 01 too low, 10 too high, 11 correct
- attempts  out  4  guesses scored this game
- game_over  out  1  high in DONE
- win  out  1  high in DONE when the last result was correct
- secret_digit_1..3  out  4 each  secret value; driven only while game_over, else 0

Behaviour:
- Reset (restart high at a clk edge):
  - state=GEN; result=00; attempts=0; game_over=0; win=0; secret outputs 0.
  - LFSR=LFSR_SEED; the submit/secret_load edge registers clear to 0.
  - Restart overrides everything in any state, including mid-CHECK; the capture in progress is discarded.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Steps every cycle while restart is low, in all states.
- Edge detect: rise = level & ~level_q, where level_q is the level registered one cycle earlier. A held button counts as one press.
- GEN:
  - Entry latches max_digits as md, with 0 mapped to 1.
  - Each cycle, secret digit k (k=1..md) takes the LFSR nibble k-1 if that nibble is ≤9. A nibble >9 is rejected and that digit retries next cycle.
  - Digits k>md are forced to 0.
  - When all active digits are valid, go to IDLE.
  - submit and secret_load are ignored in GEN.
- IDLE:
  - secret_load rise with attempts==0 and all active guess digits ≤9: secret is set from the guess digits (inactive digits 0), stay in IDLE, result unchanged.
  - secret_load rise with attempts>0 is ignored.
  - submit rise: the active guess digits are captured (inactive digits forced 0), go to CHECK.
  - submit and secret_load rising in the same cycle: submit wins, load ignored.
  - max_digits changes after GEN are ignored until the next restart.
- CHECK (exactly 1 cycle):
  - Any captured active digit >9: result=00, attempts unchanged, back to IDLE.
  - Otherwise compare BCD most significant digit first (digit 3, then 2, then 1).
  - guess<secret gives 01, guess>secret gives 10, equal gives 11.
  - attempts increments by 1.
  - Correct: go to DONE with win=1.
  - Otherwise, attempts reaching MAX_ATTEMPTS: go to DONE with win=0.
  - Otherwise go to IDLE.
- Latency: submit is high at edge N after being low at N-1, so the capture happens at edge N. result and attempts update at edge N+1 and are visible after N+1.
- DONE:
  - result, attempts and win hold; game_over=1; secret digits are driven.
  - All inputs except restart are ignored.
- attempts never exceeds MAX_ATTEMPTS and never wraps.

Decomposition:
- Package number_guess_pkg:
  - result_t enum (RES_NONE, RES_LOW, RES_HIGH, RES_CORRECT).
  - eval_state_t enum (GEN, IDLE, CHECK, DONE).
  - BCD_MAX=4'd9.
  - Shared with input_control and the display driver.
- Sub-module guess_lfsr16:
  - Ports clk, restart, seed, q[15:0].
  - Reusable for future random features.

Test Plan:
- Restart held 3 cycles, then released → result=00, attempts=0, game_over=0, secret outputs 0. Within 64 cycles state leaves GEN, with every active secret digit ≤9.
- max_digits=3:
  - secret_load with guess 4,5,6 (digit_3..1) loads secret 456.
  - Submit guess 123 → result=01 two edges after the press, attempts=1.
  - Submit 789 → result=10, attempts=2.
  - Submit 456 → result=11, win=1, game_over=1, secret digits 4,5,6.
- max_digits=1, secret_load with digit_1=7: submit 2 (digit_2 and digit_3 set to 9, ignored) → result=01. Exhaust to MAX_ATTEMPTS=8 wrong guesses → game_over=1, win=0, attempts=8. A further submit leaves attempts at 8.
- Submit held high 20 cycles → attempts increments once. Guess digit_1=12 → result=00, attempts unchanged.
- Restart asserted during the CHECK cycle → next cycle state GEN, result=00, attempts=0. secret_load pressed after attempts=1 → ignored, previous secret kept.
